// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: expands CALL/RET/INT/RTI into single-word stack accesses for the memory stage.
// Optional STACK_SEQ_PERF_EN adds saturating busy_cycles/seq_count counters.
module stack_op_sequencer #(
  parameter int OPW   = 3,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           op_valid,
  input  logic [OPW-1:0] op_code,
  output logic           op_ready,
  input  logic [31:0]    pc,
  input  logic [2:0]     flags,
  input  logic           mem_wait,
  output logic           memory_read,
  output logic           memory_write,
  output logic           memory_push,
  output logic           memory_pop,
  output logic [1:0]     memory_address_select,
  output logic [1:0]     memory_write_src_select,
  output logic           pop_tag_valid,
  output logic [1:0]     pop_tag,
  output logic           stall,
  output logic           seq_done
`ifdef STACK_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] busy_cycles,
  output logic [CNT_W-1:0] seq_count
`endif
);
  typedef enum logic [2:0] {IDLE, ACC1, PUSH_PCH, PUSH_PCL, PUSH_FLG, POP_FLG, POP_PCL, POP_PCH} state_t;
  state_t state, nxt, first;
  logic [OPW-1:0] op_q;
  logic [31:0] pc_q;
  logic [2:0] flags_q;
  logic last, accept, acc, ph, pp;
  logic d_read, d_write, d_push, d_pop, d_ptv;
  logic [1:0] d_addr, d_wsrc, d_tag;
  always_comb begin
    last     = state == ACC1 || state == PUSH_FLG || state == POP_PCH || (state == PUSH_PCL && op_q != OPW'(6));
    op_ready = (state == IDLE || last) && !mem_wait;
    seq_done = last && !mem_wait;
    accept   = op_valid && op_ready;
    stall    = (op_valid && !op_ready) || (state != IDLE && !last);
    first    = op_code < OPW'(4) ? ACC1 :
               (op_code == OPW'(4) || op_code == OPW'(6)) ? PUSH_PCH :
               op_code == OPW'(5) ? POP_PCL : POP_FLG;
    nxt      = (state == IDLE || last) ? (accept ? first : IDLE) :
               state == PUSH_PCH ? PUSH_PCL :
               state == PUSH_PCL ? PUSH_FLG :
               state == POP_FLG  ? POP_PCL  :
               state == POP_PCL  ? POP_PCH  : IDLE;
    // ACC1 is only ever entered on accept, so the live op_code selects its flavour
    acc      = nxt == ACC1;
    ph       = nxt == PUSH_PCH || nxt == PUSH_PCL || nxt == PUSH_FLG;
    pp       = nxt == POP_FLG || nxt == POP_PCL || nxt == POP_PCH;
    d_read   = (acc && (op_code == OPW'(0) || op_code == OPW'(3))) || pp;
    d_write  = (acc && (op_code == OPW'(1) || op_code == OPW'(2))) || ph;
    d_push   = (acc && op_code == OPW'(2)) || ph;
    d_pop    = (acc && op_code == OPW'(3)) || pp;
    d_addr   = (ph || pp || (acc && op_code[1])) ? 2'd2 : (acc && op_code == OPW'(0)) ? 2'd1 : 2'd0;
    d_wsrc   = nxt == PUSH_PCH ? 2'd2 : nxt == PUSH_PCL ? 2'd1 : nxt == PUSH_FLG ? 2'd3 : 2'd0;
    d_tag    = nxt == POP_FLG ? 2'd2 : nxt == POP_PCH ? 2'd1 : 2'd0;
    d_ptv    = pp;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state                   <= IDLE;
      op_q                    <= '0;
      pc_q                    <= '0;
      flags_q                 <= '0;
      memory_read             <= 1'b0;
      memory_write            <= 1'b0;
      memory_push             <= 1'b0;
      memory_pop              <= 1'b0;
      memory_address_select   <= 2'd0;
      memory_write_src_select <= 2'd0;
      pop_tag_valid           <= 1'b0;
      pop_tag                 <= 2'd0;
    end else if (!mem_wait) begin
      state                   <= nxt;
      memory_read             <= d_read;
      memory_write            <= d_write;
      memory_push             <= d_push;
      memory_pop              <= d_pop;
      memory_address_select   <= d_addr;
      memory_write_src_select <= d_wsrc;
      pop_tag_valid           <= d_ptv;
      pop_tag                 <= d_tag;
      if (accept) begin
        op_q    <= op_code;
        pc_q    <= pc;
        flags_q <= flags;
      end
    end
`ifdef STACK_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      busy_cycles <= '0;
      seq_count   <= '0;
    end else begin
      if (state != IDLE && !(&busy_cycles)) busy_cycles <= busy_cycles + 1'b1;
      if (seq_done && !(&seq_count)) seq_count <= seq_count + 1'b1;
    end
`endif
endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Controller that sits in front of the memory stage and drives its push/pop, read/write and address/write-source select controls.
- Expands multi-word stack operations (CALL, RET, INT, RTI) into back-to-back single-word accesses, one per cycle.
- Captures the 32-bit PC and 3-bit flags at command accept and holds them for the whole sequence.
- Stalls upstream while a sequence is in flight and tags each popped word so write-back can rebuild PC and flags.

Parameters:
- OPW, 3, width of op_code.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  command present
- op_code  in  3  0 LOAD, 1 STORE, 2 PUSH, 3 POP, 4 CALL, 5 RET, 6 INT, 7 RTI
- op_ready  out  1  command accepted when op_valid & op_ready
- pc  in  32  PC to save, sampled at accept
- flags  in  3  flags to save, sampled at accept
- mem_wait  in  1  memory not ready; sequencer holds current access
- memory_read  out  1  read strobe
- memory_write  out  1  write strobe
- memory_push  out  1  push strobe (SP pre-decrement in memory stage)
- memory_pop  out  1  pop strobe
- memory_address_select  out  2  0 std_address, 1 ldd_address, 2 SP
- memory_write_src_select  out  2  0 register data, 1 PC[15:0], 2 PC[31:16], 3 {13'b0, flags}
- pop_tag_valid  out  1  current access returns a stack word for PC/flags
- pop_tag  out  2  0 PC low, 1 PC high, 2 flags
- stall  out  1  hold upstream pipeline
- seq_done  out  1  one-cycle pulse on completion of the final access of any op

Behaviour:
- FSM states:
  - IDLE
  - ACC1: single access for LOAD/STORE/PUSH/POP
  - PUSH_PCH, PUSH_PCL, PUSH_FLG
  - POP_FLG, POP_PCL, POP_PCH
- Accept: in IDLE, op_ready=1. On op_valid, latch op_code, pc and flags; go to the first state next cycle. First memory access occurs 1 cycle after accept.
- Sequences (one access per state, in the order listed):
  - LOAD/STORE/PUSH/POP: ACC1
  - CALL: PUSH_PCH, PUSH_PCL
  - INT: PUSH_PCH, PUSH_PCL, PUSH_FLG
  - RET: POP_PCL, POP_PCH
  - RTI: POP_FLG, POP_PCL, POP_PCH
- Outputs are a registered Moore decode of the state:
  - LOAD: read=1, addr_sel=1.
  - STORE: write=1, addr_sel=0, wsrc=0.
  - PUSH states: push=1, write=1, addr_sel=2; wsrc is 0 in ACC1, 2 in PUSH_PCH, 1 in PUSH_PCL, 3 in PUSH_FLG.
  - POP states: pop=1, read=1, addr_sel=2; pop_tag_valid=1 for POP_* states only; pop_tag is 2 in POP_FLG, 0 in POP_PCL, 1 in POP_PCH.
  - In IDLE all strobes are 0 and both selects are 0.
- mem_wait:
  - While mem_wait=1, state and all outputs hold.
  - seq_done is suppressed.
  - op_ready is forced to 0.
- Back-to-back: in the final state of a sequence with mem_wait=0, op_ready=1 and seq_done=1. An accepted command starts its first access on the next cycle with no IDLE bubble.
- stall = op_valid & ~op_ready, OR (state != IDLE and not in final state).
- Latched pc and flags are unaffected by changes on the pc/flags inputs mid-sequence.
- Reset, including mid-sequence:
  - FSM returns to IDLE.
  - All outputs 0 except op_ready=1.
  - Latched pc, flags and op_code clear to 0.
  - No partial sequence resumes after reset deasserts.
- Undefined-state recovery: any illegal state encoding goes to IDLE on the next clock.

Optional Feature:
- Macro: STACK_SEQ_PERF_EN.
- Defined:
  - Adds outputs busy_cycles [CNT_W] and seq_count [CNT_W].
  - busy_cycles increments each cycle state != IDLE.
  - seq_count increments on each seq_done.
  - Both saturate at all-ones and clear on reset.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, then CALL with pc=32'h0001_2345:
  - Cycle+1: push=1, wsrc=2 (0x0001).
  - Cycle+2: push=1, wsrc=1 (0x2345), seq_done=1, op_ready=1.
  - stall=1 on cycle+1 only.
- INT with pc=32'hABCD_0010, flags=3'b101: three push cycles with wsrc 2, 1, 3 in order. Changing pc on cycle+1 to 0 does not alter PC[31:16]/PC[15:0] selection timing or seq_done on cycle+3.
- RTI: pop_tag sequence 2, 0, 1 with pop=1, read=1, addr_sel=2 each cycle; seq_done on the third access only.
- RET with mem_wait=1 during POP_PCL for 2 cycles: outputs frozen 3 cycles total, then POP_PCH. seq_done appears exactly once.
- Back-to-back STORE then LOAD with op_valid held: write cycle with addr_sel=0, then read cycle with addr_sel=1 on the next cycle, no idle gap.
- Reset asserted during PUSH_PCL of INT: all strobes 0 immediately (async). After release: IDLE, op_ready=1, no PUSH_FLG issued.
